// File: rtl/noc_edge_injector.sv
// Mesh edge packet transmitter. It pairs a descriptor with words from a payload FIFO and
// sends them as head/body/tail flits on the up port, using a valid/ready handshake.
module noc_edge_injector #(
  parameter int DATA_WIDTH  = 32,
  parameter int COORD_WIDTH = 2,
  parameter int LEN_WIDTH   = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int SRC_X       = 0,
  parameter int SRC_Y       = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [COORD_WIDTH-1:0] desc_dst_x,
  input  logic [COORD_WIDTH-1:0] desc_dst_y,
  input  logic [LEN_WIDTH-1:0]   desc_len,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   up_valid,
  input  logic                   up_ready,
  output logic [1:0]             up_type,
  output logic [DATA_WIDTH-1:0]  up_data,
  output logic                   busy,
  output logic [15:0]            pkt_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // Once the sender raises valid, it holds valid and the payload stable until ready is seen.

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int HDR_PAD = DATA_WIDTH - 4*COORD_WIDTH - LEN_WIDTH;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t                 state;
  logic [COORD_WIDTH-1:0] dst_x_q, dst_y_q;
  logic [LEN_WIDTH-1:0]   len_q, remaining;
  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W:0]         count;
  logic                   full, empty, push, pop, desc_take;
  logic [DATA_WIDTH-1:0]  header;

  assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count == '0);

  // wr_ready looks only at the current occupancy, so a pop in the same cycle does not let a push in.
  assign wr_ready   = rst && !full;
  assign desc_ready = rst && (state == IDLE);
  assign busy       = (state != IDLE);

  assign push      = wr_valid && wr_ready;
  assign pop       = (state == BODY) && !empty && up_ready;
  assign desc_take = desc_valid && desc_ready;

  assign header = {dst_x_q, dst_y_q, COORD_WIDTH'(SRC_X), COORD_WIDTH'(SRC_Y),
                   len_q, {HDR_PAD{1'b0}}};

  always_comb begin
    up_valid = 1'b0;
    up_type  = 2'b00;
    up_data  = '0;
    case (state)
      HEAD: begin
        up_valid = 1'b1;
        up_type  = (len_q == '0) ? 2'b11 : 2'b01;
        up_data  = header;
      end
      BODY: begin
        up_valid = !empty;
        up_type  = (remaining == LEN_WIDTH'(1)) ? 2'b10 : 2'b00;
        up_data  = mem[rd_ptr];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      dst_x_q   <= '0;
      dst_y_q   <= '0;
      len_q     <= '0;
      remaining <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);

      case (state)
        IDLE: begin
          if (desc_take) begin
            dst_x_q <= desc_dst_x;
            dst_y_q <= desc_dst_y;
            len_q   <= desc_len;
            state   <= HEAD;
          end
        end
        HEAD: begin
          if (up_ready) begin
            if (len_q == '0) begin
              pkt_count <= pkt_count + 16'd1;
              state     <= IDLE;
            end else begin
              remaining <= len_q;
              state     <= BODY;
            end
          end
        end
        BODY: begin
          if (pop) begin
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              pkt_count <= pkt_count + 16'd1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/noc_edge_injector.md
Name: noc_edge_injector

Overview:
- Packet transmitter that sits on one mesh edge port and drives the "up" (into-mesh) direction of a node port.
- Accepts a packet descriptor and a stream of payload words from a local client, then serialises them into head/body/tail flits with a valid/ready handshake toward the mesh router.
- Acts as the source end for the traffic that edge endpoints consume on the "down" direction.
- Used in mesh-level benches and as the edge attachment for traffic generators.

Parameters:
- DATA_WIDTH, 32: payload bits per flit (excluding the 2-bit flit type).
- COORD_WIDTH, 2: width of each X/Y mesh coordinate.
- LEN_WIDTH, 3: width of the body-flit count; a packet carries 0..2^LEN_WIDTH-1 body words.
- FIFO_DEPTH, 4: payload FIFO entries; power of two, ≥2.
- SRC_X, 0: this port's X coordinate, placed in the header.
- SRC_Y, 0: this port's Y coordinate, placed in the header.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- desc_valid  in  1  client offers a packet descriptor.
- desc_ready  out  1  descriptor accepted when desc_valid && desc_ready.
- desc_dst_x  in  COORD_WIDTH  destination X.
- desc_dst_y  in  COORD_WIDTH  destination Y.
- desc_len  in  LEN_WIDTH  number of body words following the header.
- wr_valid  in  1  client offers a payload word.
- wr_ready  out  1  payload FIFO not full.
- wr_data  in  DATA_WIDTH  payload word.
- up_valid  out  1  flit valid toward the mesh.
- up_ready  in  1  mesh accepts the flit this cycle.
- up_type  out  2  flit type: 01 head, 00 body, 10 tail, 11 head+tail.
- up_data  out  DATA_WIDTH  flit payload.
- busy  out  1  a packet is in flight (state ≠ IDLE).
- pkt_count  out  16  packets fully sent; wraps modulo 2^16.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, FIFO emptied, descriptor register cleared.
  - up_valid=0, up_type=00, up_data=0, busy=0, pkt_count=0.
  - desc_ready=0 and wr_ready=0 while rst=0.
  - Reset mid-packet abandons the packet; no tail is emitted.
- Descriptor register:
  - desc_ready=1 only in IDLE with no descriptor held.
  - On acceptance, latch dst_x, dst_y and len; go to HEAD on the next cycle.
- Payload FIFO:
  - wr_ready = !full. No bypass: a push while full is refused even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle while neither full nor empty leave the occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Payload words may arrive before, with, or after their descriptor.
- Header flit data:
  - Bits [DATA_WIDTH-1 -: 4*COORD_WIDTH] = {dst_x, dst_y, SRC_X, SRC_Y}.
  - Next LEN_WIDTH bits = len.
  - All remaining bits 0.
- FSM:
  - IDLE: up_valid=0. Leave on descriptor acceptance → HEAD.
  - HEAD: up_valid=1; up_type=11 if len==0, else 01.
    - On handshake with len==0: pkt_count+1, → IDLE.
    - On handshake with len>0: load remaining=len, → BODY.
  - BODY: up_valid = !fifo_empty; up_data = FIFO head; up_type=10 if remaining==1, else 00.
    - On handshake: pop, remaining−1.
    - If remaining was 1: pkt_count+1, → IDLE.
    - If the FIFO is empty, wait with up_valid=0 (bubble allowed).
- Handshake rules:
  - Once up_valid=1, up_valid, up_type and up_data stay stable until up_ready=1.
  - up_ready while up_valid=0 has no effect.
  - Minimum latency from descriptor acceptance to head flit valid: 1 cycle.
  - Back-to-back packets: the next descriptor is accepted in the IDLE cycle, so there is at least one idle cycle between a tail and the next head.
- Width rules:
  - remaining is LEN_WIDTH bits.
  - pkt_count is a free-running 16-bit counter that wraps from 0xFFFF to 0x0000.

Test Plan:
- Reset then desc (dst=2,1, len=0) with SRC=0,0 → one cycle later up_valid=1, up_type=11, header coords={2,1,0,0}; with up_ready=1, pkt_count=1, busy=0.
- Preload 3 words A,B,C; desc len=3, up_ready held 1 → flits head(01), A(00), B(00), C(10) on consecutive cycles; FIFO empty; pkt_count=1.
- Backpressure: len=2, up_ready low for 5 cycles on the head and on the first body flit → up_valid, type and data held constant throughout; sequence completes intact.
- FIFO boundary: push 5 words with FIFO_DEPTH=4 and no descriptor → wr_ready=0 after the 4th; 5th not accepted. Then send len=4 → all 4 words out in order, and wr_ready returns to 1 the cycle after the first pop.
- Starvation: desc len=2 with an empty FIFO → head sent, then up_valid=0 until a word is pushed; that word is then sent as body(00), and the second as tail(10).
- Reset mid-packet: rst=0 during BODY → the next cycle has up_valid=0, busy=0, FIFO empty, pkt_count=0; a new len=0 packet afterwards transmits normally.
